// File: rtl/da_pkg.sv
// Shared constants for the distributed-arithmetic FIR dot-product engine.
// Holds the default tap set, the datapath widths and the frame length.
package da_pkg;

    localparam int DW    = 8;
    localparam int AW    = 32;
    localparam int NBITS = 8;
    localparam int NTAPS = 8;
    localparam int CW    = $clog2(NBITS);

    // Symmetric low-pass default; index 0 is unused so taps read as 1..8.
    localparam logic signed [15:0] COEF_DEF [0:NTAPS] = '{
        16'sd0,
        16'sd1, 16'sd2, 16'sd3, 16'sd4,
        16'sd4, 16'sd3, 16'sd2, 16'sd1
    };

endpackage

// File: rtl/distr_arith_unit_if.sv
// Sample inputs and observation outputs of the DA engine bundled as one port.
// The slave side is the engine; the master side is whoever feeds the delay-line taps.
interface distr_arith_unit_if;
    import da_pkg::*;

    logic [DW-1:0]        x1_bit;
    logic [DW-1:0]        x2_bit;
    logic [DW-1:0]        x3_bit;
    logic [DW-1:0]        x4_bit;
    logic [DW-1:0]        x5_bit;
    logic [DW-1:0]        x6_bit;
    logic [DW-1:0]        x7_bit;
    logic [DW-1:0]        x8_bit;
    logic signed [AW-1:0] sum;
    logic signed [AW-1:0] dff0_out;
    logic                 count_reach;
    logic signed [AW-1:0] add6_out;
    logic signed [AW-1:0] add7_out;
    logic signed [AW-1:0] leftshift_out;

    modport master (
        output x1_bit, x2_bit, x3_bit, x4_bit,
        output x5_bit, x6_bit, x7_bit, x8_bit,
        input  sum, dff0_out, count_reach, add6_out, add7_out, leftshift_out
    );

    modport slave (
        input  x1_bit, x2_bit, x3_bit, x4_bit,
        input  x5_bit, x6_bit, x7_bit, x8_bit,
        output sum, dff0_out, count_reach, add6_out, add7_out, leftshift_out
    );

endinterface

// File: rtl/da_lut4.sv
// Four-tap coefficient-sum lookup: adds each coefficient whose bit-plane bit is set.
// Built as an adder tree rather than a 16-entry ROM so coefficients stay parameters.
module da_lut4
    import da_pkg::*;
(
    input  logic [3:0]           bits,
    input  logic signed [15:0]   coef0,
    input  logic signed [15:0]   coef1,
    input  logic signed [15:0]   coef2,
    input  logic signed [15:0]   coef3,
    output logic signed [AW-1:0] psum
);

    logic signed [AW-1:0] term0;
    logic signed [AW-1:0] term1;
    logic signed [AW-1:0] term2;
    logic signed [AW-1:0] term3;

    always_comb begin
        term0 = bits[0] ? AW'(coef0) : '0;
        term1 = bits[1] ? AW'(coef1) : '0;
        term2 = bits[2] ? AW'(coef2) : '0;
        term3 = bits[3] ? AW'(coef3) : '0;
        psum  = (term0 + term1) + (term2 + term3);
    end

endmodule

// File: rtl/distr_arith_unit.sv
// Bit-serial DA dot product: one bit-plane per clk3 cycle, MSB first, free-running 8-cycle frame.
// Samples are captured at count 0; the sign plane is subtracted, the rest shift-accumulated.
module distr_arith_unit
    import da_pkg::*;
#(
    parameter logic signed [15:0] COEF1 = COEF_DEF[1],
    parameter logic signed [15:0] COEF2 = COEF_DEF[2],
    parameter logic signed [15:0] COEF3 = COEF_DEF[3],
    parameter logic signed [15:0] COEF4 = COEF_DEF[4],
    parameter logic signed [15:0] COEF5 = COEF_DEF[5],
    parameter logic signed [15:0] COEF6 = COEF_DEF[6],
    parameter logic signed [15:0] COEF7 = COEF_DEF[7],
    parameter logic signed [15:0] COEF8 = COEF_DEF[8]
)
(
    input  logic               clk3,
    input  logic               reset,
    distr_arith_unit_if.slave  bus
);

    logic [CW-1:0]        count_q, count_d;
    logic [DW-1:0]        xr_q [NTAPS];
    logic [DW-1:0]        xr_d [NTAPS];
    logic signed [AW-1:0] acc_q, acc_d;
    logic signed [AW-1:0] sum_q, sum_d;

    logic [DW-1:0]        x_in [NTAPS];
    logic [NTAPS-1:0]     bplane;
    logic                 first_plane;
    logic                 last_plane;
    logic signed [AW-1:0] add6;
    logic signed [AW-1:0] add7;
    logic signed [AW-1:0] lut;
    logic signed [AW-1:0] acc_shl;

    assign x_in[0] = bus.x1_bit;
    assign x_in[1] = bus.x2_bit;
    assign x_in[2] = bus.x3_bit;
    assign x_in[3] = bus.x4_bit;
    assign x_in[4] = bus.x5_bit;
    assign x_in[5] = bus.x6_bit;
    assign x_in[6] = bus.x7_bit;
    assign x_in[7] = bus.x8_bit;

    assign first_plane = (count_q == '0);
    assign last_plane  = (count_q == CW'(NBITS - 1));

    // The sign plane is read straight from the inputs so no extra cycle of latency is spent capturing.
    always_comb begin
        bplane = '0;
        for (int i = 0; i < NTAPS; i++) begin
            if (first_plane) begin
                bplane[i] = x_in[i][DW-1];
            end else begin
                bplane[i] = xr_q[i][CW'(DW - 1) - count_q];
            end
        end
    end

    da_lut4 u_lut_lo (
        .bits  (bplane[3:0]),
        .coef0 (COEF1),
        .coef1 (COEF2),
        .coef2 (COEF3),
        .coef3 (COEF4),
        .psum  (add6)
    );

    da_lut4 u_lut_hi (
        .bits  (bplane[7:4]),
        .coef0 (COEF5),
        .coef1 (COEF6),
        .coef2 (COEF7),
        .coef3 (COEF8),
        .psum  (add7)
    );

    assign lut     = add6 + add7;
    assign acc_shl = acc_q << 1;

    always_comb begin
        count_d = count_q + 1'b1;
        for (int i = 0; i < NTAPS; i++) begin
            xr_d[i] = first_plane ? x_in[i] : xr_q[i];
        end
        acc_d = first_plane ? -lut : (acc_shl + lut);
        sum_d = last_plane ? (acc_shl + lut) : sum_q;
    end

    always_ff @(posedge clk3) begin
        if (reset) begin
            count_q <= '0;
            acc_q   <= '0;
            sum_q   <= '0;
            for (int i = 0; i < NTAPS; i++) begin
                xr_q[i] <= '0;
            end
        end else begin
            count_q <= count_d;
            acc_q   <= acc_d;
            sum_q   <= sum_d;
            for (int i = 0; i < NTAPS; i++) begin
                xr_q[i] <= xr_d[i];
            end
        end
    end

    assign bus.sum           = sum_q;
    assign bus.dff0_out      = acc_q;
    assign bus.count_reach   = last_plane;
    assign bus.add6_out      = add6;
    assign bus.add7_out      = add7;
    assign bus.leftshift_out = acc_shl;

endmodule

// File: tb/tb_distr_arith_unit.sv
// Directed bench for distr_arith_unit with the default taps 1,2,3,4,4,3,2,1.
// Expected sums are hand-computed dot products of the captured samples.
module tb_distr_arith_unit;

    logic clk3;
    logic reset;
    int   tests;
    int   fails;

    distr_arith_unit_if da_if ();

    distr_arith_unit dut (
        .clk3  (clk3),
        .reset (reset),
        .bus   (da_if.slave)
    );

    initial clk3 = 1'b0;
    always #5 clk3 = ~clk3;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_inputs(input logic [63:0] xs);
        da_if.x1_bit = xs[63:56];
        da_if.x2_bit = xs[55:48];
        da_if.x3_bit = xs[47:40];
        da_if.x4_bit = xs[39:32];
        da_if.x5_bit = xs[31:24];
        da_if.x6_bit = xs[23:16];
        da_if.x7_bit = xs[15:8];
        da_if.x8_bit = xs[7:0];
    endtask

    // Called just after an edge that leaves count at 0; returns at count 0 again.
    task automatic run_frame(input string tag, input logic [63:0] xs,
                             input logic [31:0] exp_a6, input logic [31:0] exp_a7,
                             input logic [31:0] prev_sum, input logic [31:0] exp_sum,
                             input bit scramble);
        logic [31:0] exp_acc1;
        exp_acc1 = -(exp_a6 + exp_a7);
        set_inputs(xs);
        #1;
        check({tag, "_add6_c0"}, da_if.add6_out, exp_a6);
        check({tag, "_add7_c0"}, da_if.add7_out, exp_a7);
        for (int i = 1; i <= 8; i++) begin
            @(posedge clk3);
            #1;
            if (i == 1) begin
                check({tag, "_acc_c1"}, da_if.dff0_out, exp_acc1);
                check({tag, "_shl_c1"}, da_if.leftshift_out, exp_acc1 << 1);
            end
            if (i == 7) begin
                check({tag, "_sum_hold"}, da_if.sum, prev_sum);
                check({tag, "_reach"}, {31'd0, da_if.count_reach}, 32'd1);
            end
            if (scramble && i < 8) set_inputs({$urandom, $urandom});
        end
        check({tag, "_sum"}, da_if.sum, exp_sum);
        check({tag, "_reach_off"}, {31'd0, da_if.count_reach}, 32'd0);
    endtask

    initial begin
        tests = 0;
        fails = 0;
        reset = 1'b1;
        set_inputs(64'd0);

        @(posedge clk3);
        #1;
        check("rst_sum", da_if.sum, 32'd0);
        check("rst_acc", da_if.dff0_out, 32'd0);
        check("rst_reach", {31'd0, da_if.count_reach}, 32'd0);
        reset = 1'b0;

        for (int n = 1; n <= 8; n++) begin
            @(posedge clk3);
            #1;
            if (n <= 7) check("reach_seq", {31'd0, da_if.count_reach}, (n == 7) ? 32'd1 : 32'd0);
        end

        run_frame("unity",  64'h0101010101010101, 32'd0,  32'd0, 32'd0,        32'd20,       1'b0);
        run_frame("sign",   64'h8000000000000000, 32'd1,  32'd0, 32'd20,       32'hFFFFFF80, 1'b0);
        run_frame("weight", 64'h0102040810204080, 32'd0,  32'd1, 32'hFFFFFF80, 32'h000000D1, 1'b0);
        run_frame("max",    64'h7F7F7F7F7F7F7F7F, 32'd0,  32'd0, 32'h000000D1, 32'd2540,     1'b0);
        run_frame("min",    64'h8080808080808080, 32'd10, 32'd10, 32'd2540,    32'hFFFFF600, 1'b0);
        run_frame("scram",  64'h0102030405060708, 32'd0,  32'd0, 32'hFFFFF600, 32'd90,       1'b1);

        set_inputs(64'h7F7F7F7F7F7F7F7F);
        for (int n = 1; n <= 4; n++) begin
            @(posedge clk3);
            #1;
        end
        reset = 1'b1;
        @(posedge clk3);
        #1;
        check("mid_rst_sum", da_if.sum, 32'd0);
        check("mid_rst_acc", da_if.dff0_out, 32'd0);
        check("mid_rst_shl", da_if.leftshift_out, 32'd0);
        check("mid_rst_reach", {31'd0, da_if.count_reach}, 32'd0);
        reset = 1'b0;

        run_frame("restart", 64'h0101010101010101, 32'd0, 32'd0, 32'd0, 32'd20, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/distr_arith_unit.md
Name: distr_arith_unit

Overview:
- 8-tap FIR dot-product engine using bit-serial distributed arithmetic (DA).
- Each 8-cycle frame it captures eight signed 8-bit samples and processes one bit-plane per cycle, MSB first.
- A coefficient-sum lookup and a shift-accumulate produce sum = Σ COEFi·xi.
- Sits between the sample delay line (which supplies x1..x8) and the output stage of the FIR datapath.

Parameters:
- COEF1..COEF8, defaults 1,2,3,4,4,3,2,1: signed tap coefficients, 16-bit two's complement.
- DW, default 8: sample width. Fixed at 8; the counter and bit-select logic are sized for it.
- AW, default 32: accumulator and output width.

Ports:
- clk3  in  1  single clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- x1_bit..x8_bit  in  8 each  signed two's-complement samples for taps 1..8.
- sum  out  32  registered frame result, signed.
- dff0_out  out  32  accumulator register contents.
- count_reach  out  1  high while the bit counter equals 7 (last bit-plane of the frame).
- add6_out  out  32  partial LUT sum for taps 1-4, sign-extended.
- add7_out  out  32  partial LUT sum for taps 5-8, sign-extended.
- leftshift_out  out  32  combinational value dff0_out << 1.

Behaviour:
- Reset (sampled on a clk3 edge):
  - count, acc, sum and the sample registers xr1..xr8 all become 0.
  - count_reach therefore reads 0 after reset.
  - Reset mid-frame aborts the frame and the next frame starts at count 0.
- Counter: 3 bits, increments every cycle, wraps 7 → 0. No enable; the block free-runs.
- Bit-plane at count k, per tap i:
  - k = 0: bi = xi_bit[7], taken live from the input. On this same edge xr_i <= xi_bit.
  - k ≠ 0: bi = xr_i[7-k].
  - Inputs are only sampled at count 0; input changes on other cycles are ignored.
- LUT:
  - add6_out = Σ_{i=1..4} bi·COEFi.
  - add7_out = Σ_{i=5..8} bi·COEFi.
  - Both are combinational and sign-extended to 32 bits.
  - lut = add6_out + add7_out.
- Accumulator (register dff0_out):
  - count 0: acc <= -lut. This is the sign-bit plane; it is subtracted, and the previous frame's value is discarded.
  - count 1..7: acc <= leftshift_out + lut.
- Result:
  - On the edge where count = 7: sum <= leftshift_out + lut.
  - sum holds that value until the next frame's count-7 edge.
- Latency: samples present during the count-0 cycle appear on sum 8 edges later (at the count-7 edge).
- Arithmetic:
  - All 32-bit signed; wrap-around on overflow.
  - Overflow cannot occur for 8-bit samples with 16-bit coefficients.
- count_reach: combinational decode of count == 7.

Decomposition:
- Package da_pkg holds:
  - default coefficient constants COEF_DEF[1..8];
  - DW/AW localparams;
  - the frame-length constant NBITS = 8.
- Sub-module da_lut4: combinational, takes a 4-bit bit-plane and four coefficients, outputs a 32-bit partial sum.
  - Instantiated twice: taps 1-4 drive add6_out, taps 5-8 drive add7_out.
- Counter, sample registers and accumulator live in the top module.

Test Plan:
- Reset: assert reset for one edge → sum = 0, dff0_out = 0, count_reach = 0. After release, count_reach is first high on the 8th cycle.
- Unity samples: all xi = 1 captured at count 0 → after the count-7 edge, sum = 20 (0x00000014).
- Sign handling: x1 = 8'h80, others 0 → sum = -128 (0xFFFFFF80). On that frame's count-0 cycle add6_out = 1 and add7_out = 0.
- Weighted vector: x1..x8 = 01,02,04,08,10,20,40,80 → sum = 1+4+12+32+64+96+128-128 = 209 (0x000000D1).
- Extremes:
  - all xi = 8'h7F → sum = 2540;
  - all xi = 8'h80 → sum = -2560;
  - on the count-0 cycle of the 8'h80 frame, add6_out = 10 and add7_out = 10.
- Input/reset robustness:
  - Change inputs every cycle within a frame → sum depends only on the count-0 capture.
  - Assert reset mid-frame (count = 4) → all outputs 0 next cycle and the frame restarts; sum stays 0 until the new frame completes.
